// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared constants and types for the std cache write-path scheduler
package std_cache_pkg;

  localparam int unsigned AW_W_SCHED_NR_PORTS = 3;
  localparam int unsigned AW_W_SCHED_DEPTH    = 4;

  localparam int unsigned ICACHE_SRC = 0;
  localparam int unsigned BYPASS_SRC = 1;
  localparam int unsigned DCACHE_SRC = 2;

  typedef logic [$clog2(AW_W_SCHED_NR_PORTS)-1:0] sched_src_t;

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } sched_state_e;

endpackage

// File: rtl/std_cache_aw_w_order_fifo.sv
// rtl/std_cache_aw_w_order_fifo.sv - order queue of granted AW sources, sync reset, no fall-through
module std_cache_aw_w_order_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/std_cache_aw_w_sched.sv
// rtl/std_cache_aw_w_sched.sv - round-robin AW arbiter with in-order W steering for the shared AXI port
// Optional macro STD_CACHE_AW_W_SCHED_STALL_CNT_EN enables the full-queue stall counter.
module std_cache_aw_w_sched
  import std_cache_pkg::*;
#(
  parameter int unsigned NrPorts = 3,
  parameter int unsigned AwWidth = 64,
  parameter int unsigned WWidth  = 73,
  parameter int unsigned Depth   = AW_W_SCHED_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NrPorts*AwWidth-1:0] aw_i,
  input  logic [NrPorts-1:0]         aw_valid_i,
  output logic [NrPorts-1:0]         aw_ready_o,
  input  logic [NrPorts*WWidth-1:0]  w_i,
  input  logic [NrPorts-1:0]         w_valid_i,
  output logic [NrPorts-1:0]         w_ready_o,
  output logic [AwWidth-1:0]         aw_o,
  output logic                       aw_valid_o,
  input  logic                       aw_ready_i,
  output logic [WWidth-1:0]          w_o,
  output logic                       w_valid_o,
  input  logic                       w_ready_i,
  output logic                       busy_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int unsigned SrcW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  typedef logic [SrcW-1:0] src_t;

  sched_state_e state_q, state_d;
  src_t         rr_q, lock_q, grant, head;
  logic         grant_vld, aw_hs, w_pop, full, empty;

  function automatic src_t next_src(input src_t s);
    return (s == src_t'(NrPorts - 1)) ? '0 : s + 1'b1;
  endfunction

  // Round-robin pick; a held lock overrides it so the AXI payload stays stable.
  always_comb begin
    src_t cand;
    cand      = '0;
    grant     = lock_q;
    grant_vld = 1'b0;
    if (state_q == SCHED_LOCKED) begin
      grant_vld = 1'b1;
    end else if (!full) begin
      for (int i = 0; i < NrPorts; i++) begin
        cand = src_t'((int'(rr_q) + i) % NrPorts);
        if (!grant_vld && aw_valid_i[cand]) begin
          grant_vld = 1'b1;
          grant     = cand;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SCHED_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SCHED_IDLE && grant_vld) lock_q <= grant;
      if (aw_hs) rr_q <= next_src(grant);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE:   if (grant_vld && !aw_ready_i) state_d = SCHED_LOCKED;
      SCHED_LOCKED: if (aw_ready_i) state_d = SCHED_IDLE;
      default:      state_d = SCHED_IDLE;
    endcase
  end

  always_comb begin
    aw_valid_o        = grant_vld;
    aw_o              = aw_i[int'(grant)*AwWidth +: AwWidth];
    aw_hs             = grant_vld & aw_ready_i;
    aw_ready_o        = '0;
    aw_ready_o[grant] = aw_hs;
  end

  std_cache_aw_w_order_fifo #(
    .Width (SrcW),
    .Depth (Depth)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_hs),
    .data_i  (grant),
    .pop_i   (w_pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    w_o       = '0;
    w_valid_o = 1'b0;
    w_ready_o = '0;
    if (!empty) begin
      w_o             = w_i[int'(head)*WWidth +: WWidth];
      w_valid_o       = w_valid_i[head];
      w_ready_o[head] = w_ready_i;
    end
  end

  assign w_pop  = w_valid_o & w_ready_i & w_o[0];
  assign busy_o = ~empty;

`ifdef STD_CACHE_AW_W_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((|aw_valid_i) && full && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_std_cache_aw_w_sched.sv
// tb/tb_std_cache_aw_w_sched.sv - scoreboard bench for std_cache_aw_w_sched with queue-based reference model
module tb_std_cache_aw_w_sched;

  localparam int NP    = 3;
  localparam int AWW   = 64;
  localparam int WW    = 73;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NP*AWW-1:0] aw_i;
  logic [NP-1:0]     aw_valid_i, aw_ready_o;
  logic [NP*WW-1:0]  w_i;
  logic [NP-1:0]     w_valid_i, w_ready_o;
  logic [AWW-1:0]    aw_o;
  logic              aw_valid_o, aw_ready_i;
  logic [WW-1:0]     w_o;
  logic              w_valid_o, w_ready_i, busy_o;
  logic [31:0]       stall_cnt_o;

  always #5 clk = ~clk;

  std_cache_aw_w_sched dut (
    .clk_i (clk), .rst_i (rst_i),
    .aw_i (aw_i), .aw_valid_i (aw_valid_i), .aw_ready_o (aw_ready_o),
    .w_i (w_i), .w_valid_i (w_valid_i), .w_ready_o (w_ready_o),
    .aw_o (aw_o), .aw_valid_o (aw_valid_o), .aw_ready_i (aw_ready_i),
    .w_o (w_o), .w_valid_o (w_valid_o), .w_ready_i (w_ready_i),
    .busy_o (busy_o), .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    logic          aw_valid;
    logic [AWW-1:0] aw_o;
    logic [NP-1:0] aw_ready;
    logic          w_valid;
    logic [WW-1:0] w_o;
    logic [NP-1:0] w_ready;
    logic          busy;
    logic [31:0]   stall;
  } status_t;

  status_t        stq[$];
  logic [AWW-1:0] exp_aw[$];
  logic [WW-1:0]  exp_w[$];
  int             n_chk = 0;
  int             n_fail = 0;

  // Reference model: order queue of source ids, rr pointer, lock.
  int             mq[$];
  int             m_rr, m_lock_idx, seq;
  bit             m_lock;
  logic [31:0]    m_stall;
  logic [NP-1:0]  pend;
  logic [AWW-1:0] pay[NP];
  logic [WW-1:0]  wp[NP];
  logic [2:0]     t1_exp[4];
  logic [AWW-1:0] t2_aw;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_lock = 0; m_lock_idx = 0; m_stall = '0; pend = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    aw_valid_i = '0; w_valid_i = '0; aw_ready_i = 1'b0; w_ready_i = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic [NP-1:0] awv_in, input logic awr, input logic [NP-1:0] wv,
                       input logic wr, input logic [NP-1:0] wl);
    logic [NP-1:0] awv;
    int g, h;
    bit full, avo, hs, pop;
    status_t s;
    @(negedge clk);
    rst_i = 1'b0;
    awv = awv_in | pend;
    for (int i = 0; i < NP; i++) begin
      if (awv[i] && !pend[i]) begin
        pend[i] = 1'b1;
        seq++;
        pay[i] = {8'(i), 24'(seq), 32'($urandom)};
      end
      wp[i] = {9'($urandom), 32'($urandom), 32'($urandom)};
      wp[i][0] = wl[i];
      aw_i[i*AWW +: AWW] = pay[i];
      w_i[i*WW +: WW] = wp[i];
    end
    aw_valid_i = awv; aw_ready_i = awr; w_valid_i = wv; w_ready_i = wr;

    full = (mq.size() == DEPTH);
    g = -1;
    if (m_lock) g = m_lock_idx;
    else if (!full)
      for (int k = 0; k < NP; k++) begin
        int c = (m_rr + k) % NP;
        if (g < 0 && awv[c]) g = c;
      end
    avo = (g >= 0);
    hs = avo && awr;
    s.aw_valid = avo;
    s.aw_o = avo ? pay[g] : '0;
    s.aw_ready = hs ? NP'(1 << g) : '0;
    if (mq.size() > 0) begin
      h = mq[0];
      s.w_valid = wv[h];
      s.w_o = wp[h];
      s.w_ready = wr ? NP'(1 << h) : '0;
    end else begin
      s.w_valid = 1'b0; s.w_o = '0; s.w_ready = '0;
    end
    s.busy = (mq.size() > 0);
    s.stall = m_stall;
    stq.push_back(s);
    if (s.w_valid && wr) exp_w.push_back(s.w_o);
    pop = s.w_valid && wr && s.w_o[0];
`ifdef STD_CACHE_AW_W_SCHED_STALL_CNT_EN
    if ((|awv) && full && m_stall != '1) m_stall++;
`endif
    if (pop) void'(mq.pop_front());
    if (hs) begin
      exp_aw.push_back(pay[g]);
      pend[g] = 1'b0;
      mq.push_back(g);
      m_rr = (g + 1) % NP;
      m_lock = 0;
    end else if (avo) begin
      m_lock = 1; m_lock_idx = g;
    end
  endtask

  // Monitor: pops the expected cycle status and any expected transfer.
  initial begin
    status_t s;
    forever begin
      @(negedge clk);
      #2;
      if (stq.size() > 0) begin
        s = stq.pop_front();
        chk("aw_valid", 128'(aw_valid_o), 128'(s.aw_valid));
        if (s.aw_valid) chk("aw_payload", 128'(aw_o), 128'(s.aw_o));
        chk("aw_ready", 128'(aw_ready_o), 128'(s.aw_ready));
        chk("w_valid", 128'(w_valid_o), 128'(s.w_valid));
        chk("w_payload", 128'(w_o), 128'(s.w_o));
        chk("w_ready", 128'(w_ready_o), 128'(s.w_ready));
        chk("busy", 128'(busy_o), 128'(s.busy));
        chk("stall_cnt", 128'(stall_cnt_o), 128'(s.stall));
      end
      if (aw_valid_o && aw_ready_i) begin
        if (exp_aw.size() == 0) chk("aw_xfer_unexpected", 128'(1), 128'(0));
        else chk("aw_xfer", 128'(aw_o), 128'(exp_aw.pop_front()));
      end
      if (w_valid_o && w_ready_i) begin
        if (exp_w.size() == 0) chk("w_xfer_unexpected", 128'(1), 128'(0));
        else chk("w_xfer", 128'(w_o), 128'(exp_w.pop_front()));
      end
    end
  end

  initial begin
    rst_i = 1'b1; aw_i = '0; w_i = '0; aw_valid_i = '0; w_valid_i = '0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0; seq = 0;
    for (int i = 0; i < NP; i++) begin pay[i] = '0; wp[i] = '0; end
    t1_exp[0] = 3'b001; t1_exp[1] = 3'b010; t1_exp[2] = 3'b100; t1_exp[3] = 3'b001;
    model_reset();
    do_reset();
    cycle('0, 1'b0, '0, 1'b0, '0);

    // W from a requester with nothing queued is never forwarded.
    repeat (3) begin
      cycle('0, 1'b0, 3'b001, 1'b1, 3'b001);
      #1;
      chk("t4_w_valid", 128'(w_valid_o), 128'(0));
      chk("t4_w_ready", 128'(w_ready_o), 128'(0));
    end

    // Fill: grants 0,1,2,0 then blocked while full.
    for (int k = 0; k < 4; k++) begin
      cycle(3'b111, 1'b1, '0, 1'b0, '0);
      #1;
      chk("t1_grant", 128'(aw_ready_o), 128'(t1_exp[k]));
    end
    repeat (10) begin
      cycle(3'b111, 1'b1, '0, 1'b0, '0);
      #1;
      chk("t1_blocked", 128'(aw_valid_o), 128'(0));
    end
    @(posedge clk);
    #1;
`ifdef STD_CACHE_AW_W_SCHED_STALL_CNT_EN
    chk("t6_stall_cnt", 128'(stall_cnt_o), 128'(10));
`else
    chk("t6_stall_cnt", 128'(stall_cnt_o), 128'(0));
`endif

    // Pop and new AW together while full: grant waits one cycle.
    cycle(3'b111, 1'b1, 3'b001, 1'b1, 3'b001);
    #1;
    chk("t3_no_grant_full", 128'(aw_valid_o), 128'(0));
    cycle(3'b111, 1'b1, '0, 1'b0, '0);
    #1;
    chk("t3_grant_after_pop", 128'(aw_ready_o), 128'(3'b010));
    @(posedge clk);
    #1;
    chk("t3_busy", 128'(busy_o), 128'(1));

    // Requester 2 AW stalled 3 cycles, then a 4-beat burst.
    do_reset();
    cycle('0, 1'b0, '0, 1'b0, '0);
    cycle(3'b100, 1'b0, '0, 1'b0, '0);
    t2_aw = pay[2];
    repeat (3) begin
      #1;
      chk("t2_aw_stable", 128'(aw_o), 128'(t2_aw));
      cycle(3'b100, 1'b0, '0, 1'b0, '0);
    end
    cycle(3'b100, 1'b1, '0, 1'b0, '0);
    #1;
    chk("t2_aw_hs", 128'(aw_ready_o), 128'(3'b100));
    for (int b = 0; b < 4; b++) begin
      cycle('0, 1'b0, 3'b111, 1'b1, (b == 3) ? 3'b111 : 3'b011);
      #1;
      chk("t2_w_ready", 128'(w_ready_o), 128'(3'b100));
    end
    cycle('0, 1'b0, '0, 1'b0, '0);
    #1;
    chk("t2_busy_clear", 128'(busy_o), 128'(0));

    // Reset mid-burst with two entries queued.
    cycle(3'b001, 1'b1, '0, 1'b0, '0);
    cycle(3'b010, 1'b1, '0, 1'b0, '0);
    cycle('0, 1'b0, 3'b001, 1'b1, 3'b000);
    do_reset();
    cycle('0, 1'b0, 3'b111, 1'b1, 3'b111);
    #1;
    chk("t5_busy", 128'(busy_o), 128'(0));
    chk("t5_w_valid", 128'(w_valid_o), 128'(0));
    cycle(3'b111, 1'b1, '0, 1'b0, '0);
    #1;
    chk("t5_first_grant", 128'(aw_ready_o), 128'(3'b001));

    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      cycle(3'($urandom) & 3'($urandom), $urandom_range(0, 3) != 0, 3'($urandom),
            $urandom_range(0, 3) != 0, 3'($urandom) & 3'($urandom));
    end
    repeat (40) cycle('0, 1'b1, 3'b111, 1'b1, 3'b111);
    @(posedge clk);
    #1;
    chk("drain_busy", 128'(busy_o), 128'(0));

    @(negedge clk);
    #5;
    chk("aw_sb_empty", 128'(exp_aw.size()), 128'(0));
    chk("w_sb_empty", 128'(exp_w.size()), 128'(0));
    chk("status_sb_empty", 128'(stq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
